// File: rtl/uart_mem_dump.sv
// Reads a contiguous block of 32-bit words from a registered-read memory port and
// streams them out as 8N1 UART frames, least significant byte first.
module uart_mem_dump #(
    parameter int CLKS_PER_BIT = 200,
    parameter int ADR_W        = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ADR_W-1:0] base_adr,
    input  logic [ADR_W:0]   word_cnt,
    output logic [ADR_W-1:0] mem_adr,
    input  logic [31:0]      mem_dat,
    output logic             tx,
    output logic             busy,
    output logic             done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int RW = ADR_W + 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, START, DATA, STOP, FINISH} state_t;

    state_t          state_q;
    logic [CW-1:0]   clk_cnt_q;
    logic [2:0]      bit_q;
    logic [1:0]      byte_q;
    logic [31:0]     shift_q;
    logic [31:0]     pend_q;
    logic [ADR_W:0]  rem_q;
    logic [ADR_W-1:0] adr_q;
    logic            tx_q;
    logic            busy_q;
    logic            done_q;

    logic bit_end;
    logic more_words;
    logic last_byte;

    assign bit_end    = (clk_cnt_q == LAST);
    assign more_words = (rem_q > RW'(1));
    assign last_byte  = (byte_q == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            shift_q   <= '0;
            pend_q    <= '0;
            rem_q     <= '0;
            adr_q     <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // The line follows the state one cycle later, which places the first
            // falling edge three cycles after the accepting edge.
            case (state_q)
                START:   tx_q <= 1'b0;
                DATA:    tx_q <= shift_q[{byte_q, bit_q}];
                default: tx_q <= 1'b1;
            endcase

            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        rem_q  <= word_cnt;
                        if (word_cnt == '0) begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            adr_q   <= base_adr;
                            state_q <= FETCH;
                        end
                    end
                end
                FETCH: state_q <= LATCH;
                LATCH: begin
                    shift_q   <= mem_dat;
                    byte_q    <= '0;
                    bit_q     <= '0;
                    clk_cnt_q <= '0;
                    state_q   <= START;
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        bit_q     <= '0;
                        state_q   <= DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                            // Prefetch: next address is on the port during the first stop cycle.
                            if (last_byte && more_words) begin
                                adr_q <= adr_q + ADR_W'(1);
                            end
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (last_byte && more_words && clk_cnt_q == CW'(1)) begin
                        pend_q <= mem_dat;
                    end
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        if (!last_byte) begin
                            byte_q  <= byte_q + 2'd1;
                            state_q <= START;
                        end else if (more_words) begin
                            rem_q   <= rem_q - RW'(1);
                            byte_q  <= '0;
                            state_q <= START;
                            // With two clocks per bit the capture and the reload share an edge.
                            shift_q <= (clk_cnt_q == CW'(1)) ? mem_dat : pend_q;
                        end else begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_adr = adr_q;
    assign tx      = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_uart_mem_dump.sv
// Directed bench for uart_mem_dump: records the tx line cycle by cycle, decodes 8N1
// frames and compares against hand-computed bytes, timing and address sequences.
module tb_uart_mem_dump;
    localparam int CPB   = 4;
    localparam int ADR_W = 14;
    localparam int MAXC  = 2000;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [ADR_W-1:0] base_adr;
    logic [ADR_W:0]   word_cnt;
    logic [ADR_W-1:0] mem_adr;
    logic [31:0]      mem_dat;
    logic             tx;
    logic             busy;
    logic             done;

    logic [31:0] mem [0:16383];

    int n_cmp = 0;
    int n_err = 0;

    logic             trace [$];
    logic [ADR_W-1:0] adrs [$];
    logic [7:0]       rx_bytes [$];
    int               rx_starts [$];
    int               frame_err;
    int               done_cnt;
    int               done_idx;
    logic             timed_out;
    logic             busy_at0;
    logic [ADR_W-1:0] adr_at0;
    logic             busy_after;

    uart_mem_dump #(.CLKS_PER_BIT(CPB), .ADR_W(ADR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .base_adr(base_adr), .word_cnt(word_cnt),
        .mem_adr(mem_adr), .mem_dat(mem_dat), .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_dat <= mem[mem_adr];

    // Accepting edge falls between the two negedges; trace index 0 is the cycle after it.
    task automatic run_dump(input logic [ADR_W-1:0] b, input logic [ADR_W:0] n, input int inject_at);
        int i;
        trace.delete(); adrs.delete();
        done_cnt = 0; done_idx = -1; timed_out = 1'b0; busy_after = 1'bx;
        @(negedge clk);
        base_adr = b; word_cnt = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_at0 = busy; adr_at0 = mem_adr;
        i = 0;
        while (1) begin
            trace.push_back(tx);
            adrs.push_back(mem_adr);
            if (done === 1'b1) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
            if (done_idx >= 0 && i == done_idx + 1) busy_after = busy;
            start = (i == inject_at);
            if (done_idx >= 0 && i >= done_idx + 3) break;
            if (i >= MAXC) begin timed_out = 1'b1; break; end
            i++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic decode_trace();
        int p;
        logic [7:0] v;
        rx_bytes.delete(); rx_starts.delete(); frame_err = 0;
        p = 0;
        while (p < trace.size()) begin
            if (trace[p] === 1'b0) begin
                if (p + 10 * CPB > trace.size()) begin frame_err++; break; end
                for (int j = 0; j < 8; j++) v[j] = trace[p + CPB * (1 + j) + CPB / 2];
                if (trace[p + 9 * CPB + CPB / 2] !== 1'b1) frame_err++;
                rx_bytes.push_back(v);
                rx_starts.push_back(p);
                p += 10 * CPB;
            end else begin
                p++;
            end
        end
        $display("dump base=%h cnt=%0d: %0d bytes, first start at %0d, done at %0d",
                 base_adr, word_cnt, rx_bytes.size(), (rx_starts.size() > 0) ? rx_starts[0] : -1, done_idx);
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b0; start = 1'b0; base_adr = '0; word_cnt = '0;
        repeat (5) @(negedge clk);
        n_cmp++; if (tx !== 1'b1)    begin n_err++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)  begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (mem_adr !== '0) begin n_err++; $display("FAIL reset_adr: got %h want 0000", mem_adr); end
        rst = 1'b1;
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || mem_adr !== '0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL idle_static: %0d bad cycles want 0", bad); end
        $display("reset/idle: 1000 idle cycles observed");
    endtask

    task automatic test_single();
        logic [7:0] exp_b [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
        mem[5] = 32'h12345678;
        run_dump(14'd5, 15'd1, -1);
        decode_trace();
        n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL single_timeout: got %b want 0", timed_out); end
        n_cmp++; if (busy_at0 !== 1'b1) begin n_err++; $display("FAIL single_busy0: got %b want 1", busy_at0); end
        n_cmp++; if (adr_at0 !== 14'd5) begin n_err++; $display("FAIL single_adr0: got %h want 0005", adr_at0); end
        n_cmp++; if (rx_bytes.size() !== 4) begin n_err++; $display("FAIL single_nbytes: got %0d want 4", rx_bytes.size()); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (k >= rx_bytes.size() || rx_bytes[k] !== exp_b[k]) begin
                n_err++; $display("FAIL single_byte%0d: got %h want %h", k, (k < rx_bytes.size()) ? rx_bytes[k] : 8'hxx, exp_b[k]);
            end
        end
        n_cmp++; if (frame_err !== 0) begin n_err++; $display("FAIL single_framing: got %0d errors want 0", frame_err); end
        n_cmp++; if (rx_starts.size() < 1 || rx_starts[0] !== 3) begin n_err++; $display("FAIL single_latency: got %0d want 3", (rx_starts.size() > 0) ? rx_starts[0] : -1); end
        n_cmp++; if (rx_starts.size() < 1 || done_idx - rx_starts[0] + 1 !== 160) begin n_err++; $display("FAIL single_length: got %0d want 160", (rx_starts.size() > 0) ? done_idx - rx_starts[0] + 1 : -1); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL single_done: got %0d pulses want 1", done_cnt); end
        n_cmp++; if (busy_after !== 1'b0) begin n_err++; $display("FAIL single_busy_end: got %b want 0", busy_after); end
    endtask

    task automatic test_multi();
        logic [7:0] exp_b [12] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hFF, 8'h00, 8'hFF, 8'h00,
                                   8'hEF, 8'hBE, 8'hAD, 8'hDE};
        int bad_gap;
        mem[0] = 32'hA5A5A5A5; mem[1] = 32'h00FF00FF; mem[2] = 32'hDEADBEEF;
        run_dump(14'd0, 15'd3, -1);
        decode_trace();
        n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL multi_timeout: got %b want 0", timed_out); end
        n_cmp++; if (rx_bytes.size() !== 12) begin n_err++; $display("FAIL multi_nbytes: got %0d want 12", rx_bytes.size()); end
        for (int k = 0; k < 12; k++) begin
            n_cmp++;
            if (k >= rx_bytes.size() || rx_bytes[k] !== exp_b[k]) begin
                n_err++; $display("FAIL multi_byte%0d: got %h want %h", k, (k < rx_bytes.size()) ? rx_bytes[k] : 8'hxx, exp_b[k]);
            end
        end
        bad_gap = 0;
        for (int k = 1; k < rx_starts.size(); k++) if (rx_starts[k] - rx_starts[k-1] != 40) bad_gap++;
        n_cmp++; if (bad_gap !== 0) begin n_err++; $display("FAIL multi_gaps: got %0d gaps not 40 want 0", bad_gap); end
        n_cmp++; if (rx_starts.size() < 1 || done_idx - rx_starts[0] + 1 !== 480) begin n_err++; $display("FAIL multi_length: got %0d want 480", (rx_starts.size() > 0) ? done_idx - rx_starts[0] + 1 : -1); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL multi_done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_wrap();
        logic [ADR_W-1:0] seq [$];
        logic [7:0] exp_b [8] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
        mem[16383] = 32'h11223344; mem[0] = 32'h55667788;
        run_dump(14'h3FFF, 15'd2, -1);
        decode_trace();
        seq.push_back(adrs[0]);
        for (int k = 1; k < adrs.size(); k++) if (adrs[k] !== adrs[k-1]) seq.push_back(adrs[k]);
        n_cmp++; if (seq.size() !== 2 || seq[0] !== 14'h3FFF || seq[1] !== 14'h0000) begin
            n_err++; $display("FAIL wrap_adr_seq: got %0d values first %h last %h want 3fff,0000", seq.size(), seq[0], seq[seq.size()-1]);
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (k >= rx_bytes.size() || rx_bytes[k] !== exp_b[k]) begin
                n_err++; $display("FAIL wrap_byte%0d: got %h want %h", k, (k < rx_bytes.size()) ? rx_bytes[k] : 8'hxx, exp_b[k]);
            end
        end
    endtask

    task automatic test_zero();
        int lows, moved;
        run_dump(14'd7, 15'd0, -1);
        decode_trace();
        lows = 0; moved = 0;
        foreach (trace[k]) if (trace[k] !== 1'b1) lows++;
        foreach (adrs[k]) if (adrs[k] !== 14'h0000) moved++;
        n_cmp++; if (busy_at0 !== 1'b1) begin n_err++; $display("FAIL zero_busy0: got %b want 1", busy_at0); end
        n_cmp++; if (done_idx !== 0) begin n_err++; $display("FAIL zero_done_at: got %0d want 0", done_idx); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL zero_done: got %0d pulses want 1", done_cnt); end
        n_cmp++; if (lows !== 0) begin n_err++; $display("FAIL zero_tx: got %0d low cycles want 0", lows); end
        n_cmp++; if (moved !== 0) begin n_err++; $display("FAIL zero_adr: got %0d moved cycles want 0", moved); end
        n_cmp++; if (busy_after !== 1'b0) begin n_err++; $display("FAIL zero_busy_end: got %b want 0", busy_after); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [4] = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
        int extra;
        mem[9] = 32'hCAFEF00D;
        run_dump(14'd9, 15'd1, 50);
        decode_trace();
        n_cmp++; if (rx_bytes.size() !== 4) begin n_err++; $display("FAIL busy_nbytes: got %0d want 4", rx_bytes.size()); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (k >= rx_bytes.size() || rx_bytes[k] !== exp_b[k]) begin
                n_err++; $display("FAIL busy_byte%0d: got %h want %h", k, (k < rx_bytes.size()) ? rx_bytes[k] : 8'hxx, exp_b[k]);
            end
        end
        extra = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) extra++;
        end
        n_cmp++; if (done_cnt !== 1 || extra !== 0) begin n_err++; $display("FAIL busy_ignored: got %0d dones %0d active cycles want 1 and 0", done_cnt, extra); end
    endtask

    task automatic test_mid_reset();
        logic [7:0] exp_b [4] = '{8'hEF, 8'hCD, 8'h00, 8'hAB};
        int bad;
        mem[2] = 32'hAB00CDEF;
        @(negedge clk);
        base_adr = 14'd2; word_cnt = 15'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (95) @(negedge clk);
        n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL midrst_pre_tx: got %b want 0", tx); end
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || mem_adr !== '0) begin
            n_err++; $display("FAIL midrst_async: got tx=%b busy=%b done=%b adr=%h want 1 0 0 0000", tx, busy, done, mem_adr);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL midrst_resume: got %0d active cycles want 0", bad); end
        $display("mid-frame reset applied and released");
        run_dump(14'd2, 15'd1, -1);
        decode_trace();
        n_cmp++; if (rx_starts.size() < 1 || rx_starts[0] !== 3) begin n_err++; $display("FAIL midrst_latency: got %0d want 3", (rx_starts.size() > 0) ? rx_starts[0] : -1); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (k >= rx_bytes.size() || rx_bytes[k] !== exp_b[k]) begin
                n_err++; $display("FAIL midrst_byte%0d: got %h want %h", k, (k < rx_bytes.size()) ? rx_bytes[k] : 8'hxx, exp_b[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_wrap();
        test_zero();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
